// File: rtl/rst_trigger_pkg.sv
// Shared types for the reset trigger: reset cause codes, FSM states and
// the simultaneous-event priority rule.
package rst_trigger_pkg;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'd0,
        CAUSE_BUTTON = 2'd1,
        CAUSE_WDT    = 2'd2,
        CAUSE_SW     = 2'd3
    } cause_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FIRE    = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    // Button beats watchdog beats software when events coincide.
    function automatic cause_t pick_cause(input logic btn, input logic wdt, input logic sw);
        cause_t c;
        c = CAUSE_NONE;
        if (btn)
            c = CAUSE_BUTTON;
        else if (wdt)
            c = CAUSE_WDT;
        else if (sw)
            c = CAUSE_SW;
        return c;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer followed by a stable-sample
// counter; emits the debounced level and a one-cycle strobe on its falling edge.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_n,
    output logic o_level,
    output logic o_fall
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    // Counter tracks consecutive samples that disagree with the accepted level.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync0 <= i_btn_n;
            r_sync1 <= r_sync0;
            r_fall  <= 1'b0;
            if (r_sync1 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync1;
                r_fall  <= ~r_sync1;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;

endmodule

// File: rtl/rst_trigger.sv
// Reset request generator: merges button, watchdog and software events into
// a fixed-length registered reset pulse and records which source caused it.
module rst_trigger
    import rst_trigger_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PULSE_CYCLES    = 4,
    parameter int unsigned WDT_WIDTH       = 24
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 btn_n,
    input  logic                 sw_reset_req,
    input  logic                 wdt_en,
    input  logic                 wdt_kick,
    input  logic [WDT_WIDTH-1:0] wdt_load,
    input  logic                 cause_clr,
    output logic                 trigger_reset,
    output logic [1:0]           reset_cause,
    output logic [WDT_WIDTH-1:0] wdt_count
);

    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

    logic                 w_level;
    logic                 w_fall;
    logic                 w_idle;
    logic                 w_btn_evt;
    logic                 w_wdt_evt;
    logic                 w_sw_evt;
    logic                 w_any_evt;
    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_pcnt;
    logic [7:0]           w_pcnt_nxt;
    logic                 r_trigger;
    logic                 w_trigger_nxt;
    logic [WDT_WIDTH-1:0] r_wdt;
    // Power-up value only; must survive sys_rst so software can read it.
    cause_t               r_cause = CAUSE_NONE;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_btn_n (btn_n),
        .o_level (w_level),
        .o_fall  (w_fall)
    );

    assign w_idle    = (r_state == ST_IDLE);
    assign w_btn_evt = w_idle & w_fall;
    assign w_wdt_evt = w_idle & wdt_en & ~wdt_kick & (r_wdt == '0);
    assign w_sw_evt  = w_idle & sw_reset_req;
    assign w_any_evt = w_btn_evt | w_wdt_evt | w_sw_evt;

    // Expiry reloads too, so a zero reload value fires on every enabled idle cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst || !wdt_en || !w_idle || wdt_kick || (r_wdt == '0))
            r_wdt <= wdt_load;
        else
            r_wdt <= r_wdt - WDT_WIDTH'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state   <= ST_IDLE;
            r_pcnt    <= '0;
            r_trigger <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_trigger <= w_trigger_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pcnt_nxt    = r_pcnt;
        w_trigger_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_evt) begin
                    w_state_nxt   = ST_FIRE;
                    w_pcnt_nxt    = '0;
                    w_trigger_nxt = 1'b1;
                end
            end
            ST_FIRE: begin
                if (r_pcnt == PULSE_LAST) begin
                    w_state_nxt = ST_HOLDOFF;
                end else begin
                    w_pcnt_nxt    = r_pcnt + 8'd1;
                    w_trigger_nxt = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (w_level)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst && w_any_evt)
            r_cause <= pick_cause(w_btn_evt, w_wdt_evt, w_sw_evt);
        else if (cause_clr)
            r_cause <= CAUSE_NONE;
    end

    assign trigger_reset = r_trigger;
    assign reset_cause   = r_cause;
    assign wdt_count     = r_wdt;

endmodule

// File: tb/tb_rst_trigger.sv
// Bench for rst_trigger: directed scenarios plus a random soak, every cycle
// compared against a cycle-level behavioural model of the reset trigger.
module tb_rst_trigger;

    localparam int DEB = 8;
    localparam int PUL = 4;
    localparam int WW  = 8;

    logic          sys_clk      = 1'b0;
    logic          sys_rst      = 1'b1;
    logic          btn_n        = 1'b1;
    logic          sw_reset_req = 1'b0;
    logic          wdt_en       = 1'b0;
    logic          wdt_kick     = 1'b0;
    logic [WW-1:0] wdt_load     = 8'd10;
    logic          cause_clr    = 1'b0;
    logic          trigger_reset;
    logic [1:0]    reset_cause;
    logic [WW-1:0] wdt_count;

    always #5 sys_clk = ~sys_clk;

    rst_trigger #(
        .DEBOUNCE_CYCLES(DEB),
        .PULSE_CYCLES   (PUL),
        .WDT_WIDTH      (WW)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .btn_n         (btn_n),
        .sw_reset_req  (sw_reset_req),
        .wdt_en        (wdt_en),
        .wdt_kick      (wdt_kick),
        .wdt_load      (wdt_load),
        .cause_clr     (cause_clr),
        .trigger_reset (trigger_reset),
        .reset_cause   (reset_cause),
        .wdt_count     (wdt_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model. phase: 0 waiting for events, 1 pulsing, 2 waiting for release.
    int m_s0 = 1, m_s1 = 1, m_lvl = 1, m_fall = 0;
    int m_phase = 0, m_left = 0, m_trig = 0, m_wdt = 0, m_cause = 0;
    int hist[$];

    int   pulses   = 0;
    int   high_len = 0;
    int   last_len = 0;
    logic prev_trig = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  n_lvl, n_fall, n_phase, n_left, n_wdt, n_cause;
        bit  idle, be, we, se, all_diff;
        if (sys_rst) begin
            m_s0 = 1; m_s1 = 1; m_lvl = 1; m_fall = 0;
            hist.delete();
            m_phase = 0; m_left = 0; m_trig = 0;
            m_wdt = int'(wdt_load);
            if (cause_clr) m_cause = 0;
            return;
        end
        idle = (m_phase == 0);
        be   = idle && (m_fall == 1);
        we   = idle && wdt_en && !wdt_kick && (m_wdt == 0);
        se   = idle && sw_reset_req;

        n_wdt = (!idle || !wdt_en || wdt_kick || m_wdt == 0) ? int'(wdt_load) : m_wdt - 1;

        // Level flips once the last DEB synchronized samples all disagree with it.
        hist.push_back(m_s1);
        if (hist.size() > DEB) void'(hist.pop_front());
        n_lvl  = m_lvl;
        n_fall = 0;
        if (hist.size() == DEB) begin
            all_diff = 1'b1;
            foreach (hist[i]) if (hist[i] == m_lvl) all_diff = 1'b0;
            if (all_diff) begin
                n_lvl  = 1 - m_lvl;
                n_fall = (n_lvl == 0) ? 1 : 0;
                hist.delete();
            end
        end

        n_phase = m_phase;
        n_left  = m_left;
        n_cause = m_cause;
        if (be || we || se) begin
            n_phase = 1;
            n_left  = PUL;
            n_cause = be ? 1 : (we ? 2 : 3);
        end else begin
            if (cause_clr) n_cause = 0;
            if (m_phase == 1) begin
                n_left = m_left - 1;
                if (n_left == 0) n_phase = 2;
            end else if (m_phase == 2 && m_lvl == 1) begin
                n_phase = 0;
            end
        end

        m_s1 = m_s0;
        m_s0 = int'(btn_n);
        m_lvl = n_lvl; m_fall = n_fall;
        m_phase = n_phase; m_left = n_left; m_cause = n_cause; m_wdt = n_wdt;
        m_trig = (n_phase == 1) ? 1 : 0;
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_edge();
        #1;
        chk("trigger_reset", 32'(trigger_reset), m_trig);
        chk("reset_cause", 32'(reset_cause), m_cause);
        chk("wdt_count", 32'(wdt_count), m_wdt);
        if (trigger_reset && !prev_trig) pulses++;
        if (trigger_reset) high_len++;
        else if (prev_trig) begin
            last_len = high_len;
            high_len = 0;
        end
        prev_trig = trigger_reset;
        @(negedge sys_clk);
        sw_reset_req = 1'b0;
        wdt_kick     = 1'b0;
        cause_clr    = 1'b0;
    endtask

    initial begin
        int t_first;
        int seen;
        int hold;

        #1;
        chk("powerup_cause", 32'(reset_cause), 0);
        @(negedge sys_clk);
        repeat (3) step();
        chk("reset_trigger", 32'(trigger_reset), 0);
        chk("reset_wdt", 32'(wdt_count), 10);
        sys_rst = 1'b0;
        repeat (5) step();

        // Button press with bounce, held ~22 cycles.
        pulses = 0;
        btn_n = 1'b0; step();
        btn_n = 1'b1; step();
        btn_n = 1'b0; step();
        repeat (20) step();
        btn_n = 1'b1;
        repeat (14) step();
        chk("btn_pulses", pulses, 1);
        chk("btn_pulse_len", last_len, PUL);
        chk("btn_cause", 32'(reset_cause), 1);
        sw_reset_req = 1'b1; step();
        chk("idle_after_release", 32'(trigger_reset), 1);
        repeat (6) step();
        cause_clr = 1'b1; step();
        chk("cause_clr", 32'(reset_cause), 0);

        // Watchdog expiry, then kicked watchdog.
        wdt_load = 8'd10;
        wdt_en   = 1'b1;
        pulses   = 0;
        t_first  = -1;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (trigger_reset && t_first < 0) t_first = i;
        end
        chk("wdt_pulses", pulses, 1);
        chk("wdt_cause", 32'(reset_cause), 2);
        chk("wdt_fired", (t_first > 0) ? 1 : 0, 1);
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            if (i % 5 == 0) wdt_kick = 1'b1;
            step();
        end
        chk("wdt_kicked_pulses", pulses, 0);

        // Zero reload fires on the first enabled cycle.
        wdt_en = 1'b0; wdt_load = 8'd0; step();
        wdt_en = 1'b1; step();
        chk("wdt_load0", 32'(trigger_reset), 1);
        wdt_en = 1'b0; wdt_load = 8'd10;
        repeat (8) step();
        cause_clr = 1'b1; step();

        // Software request coincident with the debounced button edge.
        pulses = 0;
        seen   = 0;
        btn_n  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (m_fall == 1) begin
                sw_reset_req = 1'b1;
                seen = 1;
            end
            step();
        end
        chk("coincident_seen", seen, 1);
        chk("coincident_pulses", pulses, 1);
        chk("coincident_cause", 32'(reset_cause), 1);
        btn_n = 1'b1;
        repeat (14) step();
        cause_clr = 1'b1; step();

        // sys_rst on the second pulse cycle.
        pulses = 0;
        sw_reset_req = 1'b1; step();
        step();
        sys_rst = 1'b1; step();
        chk("rst_midfire", 32'(trigger_reset), 0);
        chk("cause_survives_rst", 32'(reset_cause), 3);
        sys_rst = 1'b0;
        repeat (6) step();
        chk("rst_cut_pulses", pulses, 1);
        chk("rst_cut_len", last_len, 2);
        cause_clr = 1'b1; step();
        chk("cause_clr_after_rst", 32'(reset_cause), 0);

        // Software request while waiting for button release is dropped.
        pulses = 0;
        btn_n  = 1'b0;
        repeat (18) step();
        sw_reset_req = 1'b1; step();
        repeat (4) step();
        chk("holdoff_pulses", pulses, 1);
        chk("holdoff_cause", 32'(reset_cause), 1);
        btn_n = 1'b1;
        repeat (14) step();

        // Random soak.
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                btn_n = 1'($urandom_range(0, 1));
                hold  = int'($urandom_range(1, 14));
            end
            hold--;
            sw_reset_req = ($urandom_range(0, 29) == 0);
            wdt_kick     = ($urandom_range(0, 7) == 0);
            cause_clr    = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) wdt_en = ~wdt_en;
            if ($urandom_range(0, 49) == 0) wdt_load = WW'($urandom_range(0, 30));
            sys_rst = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
